// File: rtl/vscale_htif_pcr_responder.sv
// HTIF PCR responder: host read/write access to tohost/fromhost with a
// one-outstanding-request handshake. Optional cycle CSR: VSCALE_HTIF_CYCLE_CSR_EN.
module vscale_htif_pcr_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] TO_HOST_ADDR = 12'h780,
  parameter logic [ADDR_WIDTH-1:0] FROM_HOST_ADDR = 12'h781
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  htif_pcr_req_valid,
  output logic                  htif_pcr_req_ready,
  input  logic                  htif_pcr_req_rw,
  input  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
  input  logic [DATA_WIDTH-1:0] htif_pcr_req_data,
  output logic                  htif_pcr_resp_valid,
  input  logic                  htif_pcr_resp_ready,
  output logic [DATA_WIDTH-1:0] htif_pcr_resp_data,
  input  logic                  core_tohost_wen,
  input  logic [DATA_WIDTH-1:0] core_tohost_wdata,
  input  logic                  core_fromhost_wen,
  input  logic [DATA_WIDTH-1:0] core_fromhost_wdata,
  output logic [DATA_WIDTH-1:0] tohost,
  output logic [DATA_WIDTH-1:0] fromhost
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;
  logic [DATA_WIDTH-1:0] fromhost_q, fromhost_d;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  accept_s;
  logic                  hit_to_s;
  logic                  hit_from_s;

`ifdef VSCALE_HTIF_CYCLE_CSR_EN
  localparam logic [ADDR_WIDTH-1:0] CYCLE_ADDR = ADDR_WIDTH'(12'hC00);
  logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
  logic                  hit_cycle_s;
  assign hit_cycle_s = (htif_pcr_req_addr == CYCLE_ADDR);
`endif

  // Ready is gated by reset so the host never sees a stale IDLE while reset is high.
  assign htif_pcr_req_ready  = (state_q == ST_IDLE) && !reset;
  assign accept_s            = htif_pcr_req_valid && htif_pcr_req_ready;
  assign hit_to_s            = (htif_pcr_req_addr == TO_HOST_ADDR);
  assign hit_from_s          = (htif_pcr_req_addr == FROM_HOST_ADDR);
  assign htif_pcr_resp_valid = resp_valid_q;
  assign htif_pcr_resp_data  = resp_data_q;
  assign tohost              = tohost_q;
  assign fromhost            = fromhost_q;

  // Read mux: value returned for the addressed register (pre-update value).
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (hit_to_s) begin
      rd_data_s = tohost_q;
    end else if (hit_from_s) begin
      rd_data_s = fromhost_q;
`ifdef VSCALE_HTIF_CYCLE_CSR_EN
    end else if (hit_cycle_s) begin
      rd_data_s = cycle_q;
`endif
    end else begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Handshake FSM next state and registered response.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = rd_data_s;
        end else begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (htif_pcr_resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // tohost: core write wins over host read-clear or host write.
  always_comb begin
    tohost_d = tohost_q;
    if (core_tohost_wen) begin
      tohost_d = core_tohost_wdata;
    end else if (accept_s && hit_to_s) begin
      tohost_d = htif_pcr_req_rw ? htif_pcr_req_data : {DATA_WIDTH{1'b0}};
    end else begin
      tohost_d = tohost_q;
    end
  end

  // fromhost: host write wins over a coincident core write.
  always_comb begin
    fromhost_d = fromhost_q;
    if (accept_s && hit_from_s && htif_pcr_req_rw) begin
      fromhost_d = htif_pcr_req_data;
    end else if (core_fromhost_wen) begin
      fromhost_d = core_fromhost_wdata;
    end else begin
      fromhost_d = fromhost_q;
    end
  end

`ifdef VSCALE_HTIF_CYCLE_CSR_EN
  // Free-running cycle counter, wraps naturally at all-ones.
  always_comb begin
    cycle_d = cycle_q + DATA_WIDTH'(1);
  end
`endif

  // State registers with synchronous reset; pending response is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= {DATA_WIDTH{1'b0}};
      tohost_q     <= {DATA_WIDTH{1'b0}};
      fromhost_q   <= {DATA_WIDTH{1'b0}};
`ifdef VSCALE_HTIF_CYCLE_CSR_EN
      cycle_q      <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      tohost_q     <= tohost_d;
      fromhost_q   <= fromhost_d;
`ifdef VSCALE_HTIF_CYCLE_CSR_EN
      cycle_q      <= cycle_d;
`endif
    end
  end

endmodule

// File: doc/vscale_htif_pcr_responder.md
VSCALE_HTIF_PCR_RESPONDER -- requirements
Module: vscale_htif_pcr_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: width of the PCR/CSR address.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: PCR data width, equal to HTIF_PCR_WIDTH.
REQ-003 SHALL have parameter TO_HOST_ADDR, default 12'h780: address of the tohost register.
REQ-004 SHALL have parameter FROM_HOST_ADDR, default 12'h781: address of the fromhost register.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port htif_pcr_req_valid, input, 1 bit: host request valid.
REQ-008 SHALL have port htif_pcr_req_ready, output, 1 bit: responder can accept a request.
REQ-009 SHALL have port htif_pcr_req_rw, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port htif_pcr_req_addr, input, ADDR_WIDTH bits: target register.
REQ-011 SHALL have port htif_pcr_req_data, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port htif_pcr_resp_valid, output, 1 bit: response valid.
REQ-013 SHALL have port htif_pcr_resp_ready, input, 1 bit: host accepts the response.
REQ-014 SHALL have port htif_pcr_resp_data, output, DATA_WIDTH bits: response data.
REQ-015 SHALL have ports core_tohost_wen (input, 1 bit) and core_tohost_wdata (input, DATA_WIDTH bits): core-side write of tohost.
REQ-016 SHALL have ports core_fromhost_wen (input, 1 bit) and core_fromhost_wdata (input, DATA_WIDTH bits): core-side write of fromhost.
REQ-017 SHALL have ports tohost and fromhost (outputs, DATA_WIDTH bits each): current register values, for core CSR reads.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and RESP; htif_pcr_req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request when req_valid && req_ready, latch the response data, and enter RESP on the next edge.
REQ-020 SHALL assert resp_valid exactly in RESP, so that the response appears one cycle after acceptance.
REQ-021 SHALL hold resp_data stable while resp_valid && !resp_ready, and SHALL return to IDLE on resp_valid && resp_ready.
REQ-022 SHALL support at most one outstanding request; back-to-back requests are accepted at most one every two cycles.
REQ-023 SHALL, on a read of TO_HOST_ADDR, return tohost and clear tohost to 0 at acceptance (read-and-clear).
REQ-024 SHALL, on a read of FROM_HOST_ADDR, return fromhost without side effect.
REQ-025 SHALL, on a write to TO_HOST_ADDR or FROM_HOST_ADDR, store req_data and respond with the register's previous value (swap).
REQ-026 SHALL, for an unmapped address, return 0 on read and ignore the write while still producing a response.
REQ-027 SHALL, when core_tohost_wen coincides with an accepted host access to tohost, return the old value to the host and leave tohost at core_tohost_wdata, so the core value wins.
REQ-028 SHALL, when core_fromhost_wen coincides with an accepted host write of fromhost, keep the host data, so the host wins.
REQ-029 SHALL apply core writes in any FSM state, including RESP.

Reset
REQ-030 SHALL, while reset is high at a clock edge, force FSM = IDLE, tohost = 0 and fromhost = 0.
REQ-031 SHALL drive resp_valid = 0, resp_data = 0 and req_ready = 0 during reset, and req_ready = 1 in the first cycle after reset is released.
REQ-032 SHALL discard any pending response on reset mid-transaction, without completing its read-and-clear.

Configuration
REQ-033 SHALL, when VSCALE_HTIF_CYCLE_CSR_EN is defined, include a free-running DATA_WIDTH-bit cycle counter. The counter is reset to 0, increments every non-reset cycle, wraps at all-ones, reads at address 12'hC00, and ignores writes while still responding.
REQ-034 SHALL, when VSCALE_HTIF_CYCLE_CSR_EN is undefined, omit the counter and treat 12'hC00 as unmapped (reads return 0).

Verification
REQ-035 SHALL cover: core writes tohost=1 -> host read of 12'h780 returns resp_data=1 one cycle after acceptance; a second read returns 0.
REQ-036 SHALL cover: host writes fromhost=0x55 with resp_ready held 0 for 3 cycles -> resp_valid and resp_data=0 stable for 3 cycles, req_ready=0 throughout, fromhost=0x55.
REQ-037 SHALL cover: core_tohost_wen with data 0x7 in the same cycle as a host read of tohost=0x3 -> response 0x3, tohost=0x7 afterwards.
REQ-038 SHALL cover: host write 0xA and core write 0x0 to fromhost in the same cycle -> fromhost=0xA.
REQ-039 SHALL cover: read of 12'h123 -> resp_data=0; reset asserted while in RESP -> resp_valid=0 and tohost=0 on the next cycle.
REQ-040 SHALL cover: with VSCALE_HTIF_CYCLE_CSR_EN defined, two reads of 12'hC00 accepted 5 cycles apart -> values differ by 5.
